// File: rtl/sprite_address_generator.sv
// -----------------------------------------------------------------------------
// sprite_address_generator
//
// Drawing-path stage around the sprite line counter of the VGA pipeline.
// It watches the raster for the left edge of a SPRITE_SIZE x SPRITE_SIZE
// sprite window and enables the line counter (sprite_on). It turns the
// counter's column index into sprite ROM addresses. It then aligns the ROM
// data, which arrives one cycle after the address, into a qualified pixel
// stream for the colour mux. Transparent pixels are suppressed.
//
// Ports:
//   clk_pixel      in   pixel clock
//   reset          in   asynchronous reset, active low
//   video_on       in   raster inside visible area
//   pixel_x/y      in   current raster column / line
//   sprite_enable  in   sprite visible this frame
//   sprite_x/y     in   sprite top-left column / line
//   sprite_offset  in   ROM base address of the selected sprite image
//   column_index   in   column from the line counter (0..SPRITE_SIZE-1)
//   sprite_on      out  enable to the line counter
//   address_memory out  ROM address
//   address_valid  out  address_memory is a live fetch this cycle
//   mem_data       in   ROM read data, one cycle after the address
//   pixel_valid    out  pixel_color is an opaque sprite pixel
//   pixel_color    out  sprite colour (0 when no data slot)
// -----------------------------------------------------------------------------
module sprite_address_generator #(
  parameter int                    SPRITE_SIZE = 20,
  parameter int                    COORD_WIDTH = 10,
  parameter int                    ADDR_WIDTH  = 14,
  parameter int                    PIXEL_WIDTH = 9,
  parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT = 9'h1FF
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   video_on,
  input  logic [COORD_WIDTH-1:0] pixel_x,
  input  logic [COORD_WIDTH-1:0] pixel_y,
  input  logic                   sprite_enable,
  input  logic [COORD_WIDTH-1:0] sprite_x,
  input  logic [COORD_WIDTH-1:0] sprite_y,
  input  logic [ADDR_WIDTH-1:0]  sprite_offset,
  input  logic [4:0]             column_index,
  output logic                   sprite_on,
  output logic [ADDR_WIDTH-1:0]  address_memory,
  output logic                   address_valid,
  input  logic [PIXEL_WIDTH-1:0] mem_data,
  output logic                   pixel_valid,
  output logic [PIXEL_WIDTH-1:0] pixel_color
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAW     = 2'd1,
    ST_LINE_END = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [4:0]              r_row;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic                    r_sprite_on;
  logic                    r_address_valid;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic                    r_d_valid;
  logic                    r_pixel_valid;
  logic [PIXEL_WIDTH-1:0]  r_pixel_color;

  logic                    w_sprite_on_next;
  logic                    w_address_valid_next;
  logic                    w_latch;
  logic                    w_abort;
  logic                    w_hit;
  logic [COORD_WIDTH:0]    w_py_ext;
  logic [COORD_WIDTH:0]    w_sy_ext;
  logic [COORD_WIDTH:0]    w_sy_last;
  logic [4:0]              w_row;
  logic [ADDR_WIDTH-1:0]   w_address;

  // The window test is done one bit wider so sprite_y+SIZE-1 cannot wrap
  // back to the top of the screen for sprites near the bottom.
  assign w_py_ext  = {1'b0, pixel_y};
  assign w_sy_ext  = {1'b0, sprite_y};
  assign w_sy_last = w_sy_ext + (COORD_WIDTH+1)'(SPRITE_SIZE - 1);

  assign w_hit = video_on & sprite_enable & (pixel_x == sprite_x) &
                 (w_py_ext >= w_sy_ext) & (w_py_ext <= w_sy_last);

  // The row is always 0..SPRITE_SIZE-1 on a hit, so the low five bits of the
  // difference are exactly the difference of the low five bits.
  assign w_row = pixel_y[4:0] - sprite_y[4:0];

  // ROM address wraps modulo 2^ADDR_WIDTH by construction of the widths.
  assign w_address = r_base
                   + (ADDR_WIDTH'(r_row) * ADDR_WIDTH'(SPRITE_SIZE))
                   + ADDR_WIDTH'(column_index);

  // State register.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_state_next         = r_state;
    w_sprite_on_next     = 1'b0;
    w_address_valid_next = 1'b0;
    w_latch              = 1'b0;
    w_abort              = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_next     = ST_DRAW;
          w_sprite_on_next = 1'b1;
          w_latch          = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (!video_on || !sprite_enable) begin
          w_state_next = ST_IDLE;
          w_abort      = 1'b1;
        end else if (column_index == 5'(SPRITE_SIZE - 1)) begin
          // Last column still issues its fetch; sprite_on drops so the
          // counter is held at 0 during LINE_END.
          w_state_next         = ST_LINE_END;
          w_address_valid_next = 1'b1;
        end else begin
          w_state_next         = ST_DRAW;
          w_sprite_on_next     = 1'b1;
          w_address_valid_next = 1'b1;
        end
      end
      ST_LINE_END: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, latched sprite parameters and ROM alignment stage.
  always_ff @(posedge clk_pixel or negedge reset) begin
    if (!reset) begin
      r_sprite_on     <= 1'b0;
      r_address_valid <= 1'b0;
      r_address       <= {ADDR_WIDTH{1'b0}};
      r_row           <= 5'd0;
      r_base          <= {ADDR_WIDTH{1'b0}};
      r_d_valid       <= 1'b0;
      r_pixel_valid   <= 1'b0;
      r_pixel_color   <= {PIXEL_WIDTH{1'b0}};
    end else begin
      r_sprite_on     <= w_sprite_on_next;
      r_address_valid <= w_address_valid_next;
      if (w_address_valid_next) begin
        r_address <= w_address;
      end
      if (w_latch) begin
        r_row  <= w_row;
        r_base <= sprite_offset;
      end
      // An abort also discards the fetch currently in flight.
      r_d_valid     <= r_address_valid & ~w_abort;
      r_pixel_valid <= r_d_valid & (mem_data != TRANSPARENT);
      r_pixel_color <= r_d_valid ? mem_data : {PIXEL_WIDTH{1'b0}};
    end
  end

  assign sprite_on      = r_sprite_on;
  assign address_memory = r_address;
  assign address_valid  = r_address_valid;
  assign pixel_valid    = r_pixel_valid;
  assign pixel_color    = r_pixel_color;

endmodule

// File: doc/sprite_address_generator.md
Name: sprite_address_generator

Overview:
Drawing-path stage wrapped around the sprite line counter in the DE0-Nano VGA pipeline. Upstream role: detects the raster entering a SPRITE_SIZE x SPRITE_SIZE sprite window and drives sprite_on to the counter. Downstream role: consumes the counter's column index to form sprite ROM addresses. Aligns the one-cycle ROM data into a qualified pixel stream for the VGA colour mux, with transparency suppression.

Parameters:
SPRITE_SIZE, 20, sprite width and height in pixels; matches counter states 0..19.
COORD_WIDTH, 10, width of raster and sprite coordinates.
ADDR_WIDTH, 14, sprite ROM address width.
PIXEL_WIDTH, 9, colour word width (3 bits per R/G/B).
TRANSPARENT, 9'h1FF, colour code treated as transparent.

Ports:
clk_pixel  input  1  pixel clock (VGA).
reset  input  1  asynchronous, active-low reset.
video_on  input  1  raster inside visible area.
pixel_x  input  COORD_WIDTH  current raster column.
pixel_y  input  COORD_WIDTH  current raster line.
sprite_enable  input  1  sprite visible this frame.
sprite_x  input  COORD_WIDTH  sprite top-left column.
sprite_y  input  COORD_WIDTH  sprite top-left line.
sprite_offset  input  ADDR_WIDTH  ROM base address of the selected sprite image.
column_index  input  5  current column from line counter (0..SPRITE_SIZE-1).
sprite_on  output  1  enable to line counter.
address_memory  output  ADDR_WIDTH  ROM address.
address_valid  output  1  address_memory is a live fetch this cycle.
mem_data  input  PIXEL_WIDTH  ROM read data, one cycle after address.
pixel_valid  output  1  pixel_color is an opaque sprite pixel.
pixel_color  output  PIXEL_WIDTH  sprite colour.

Behaviour:
- Reset (reset low, async): state IDLE; sprite_on 0; address_memory 0; address_valid 0; pixel_valid 0; pixel_color 0; row register 0. Reset low mid-line forces all of these immediately.
- Hit condition (combinational):
  - video_on & sprite_enable & pixel_x == sprite_x & pixel_y >= sprite_y & pixel_y <= sprite_y+SPRITE_SIZE-1.
  - Comparisons are done in COORD_WIDTH+1 bits so sprite_y+SIZE never wraps.
- FSM (posedge clk_pixel):
  - IDLE: sprite_on 0, address_valid 0. On hit: go to DRAW; latch row = pixel_y - sprite_y (5 bits); latch base = sprite_offset.
  - DRAW: sprite_on 1.
    - Each cycle: address_memory = base + row*SPRITE_SIZE + column_index, registered; address_valid 1.
    - Arithmetic is modulo 2^ADDR_WIDTH.
    - When column_index == SPRITE_SIZE-1 is sampled, go to LINE_END.
    - If video_on or sprite_enable goes low, abort to IDLE (sprite_on 0, address_valid 0 next cycle).
  - LINE_END: one cycle. sprite_on 0, forcing the counter back to 0. address_valid 0. Then IDLE; a new hit in this cycle is ignored.
- Latency:
  - sprite_on rises the cycle after the hit.
  - Exactly SPRITE_SIZE address_valid cycles occur per uninterrupted line, with column 0..19 in order.
  - Sprite position and offset inputs are ignored outside IDLE; they are latched at the hit.
- Output stage: the ROM is synchronous with 1-cycle latency.
  - address_valid is delayed 1 cycle to form d_valid.
  - pixel_valid = d_valid & (mem_data != TRANSPARENT), registered.
  - pixel_color = mem_data when d_valid, else 0, registered.
  - First pixel_valid therefore appears 2 cycles after the first address_valid.
- An abort drops the in-flight address's pixel (d_valid cleared with address_valid).
- One sprite line per raster line; at most one DRAW entry per line, since the hit is edge-exact on pixel_x.

Test Plan:
- Reset release, sprite_enable 0, full frame -> sprite_on, address_valid, pixel_valid never assert; all outputs 0.
- sprite_x=100, sprite_y=50, sprite_offset=400, raster line 53 -> sprite_on high for the cycles after pixel_x=100; addresses 460..479 in order with address_valid for 20 cycles; one LINE_END cycle with sprite_on 0.
- Same setup, ROM returns 9'h1FF for column 5, 9'h038 elsewhere -> pixel_valid low exactly on the 6th data slot; pixel_color 9'h038 on the other 19 slots, each 2 cycles after its address.
- sprite_y=1020 (bottom overflow), raster line 3 -> no hit (no wrap); line 1023 -> row 3 drawn.
- video_on drops after 7 addresses -> sprite_on 0 and address_valid 0 next cycle; the in-flight pixel is suppressed; FSM back in IDLE.
- Reset asserted mid-DRAW at column 10 -> all outputs 0 immediately; after release, the next hit restarts at column 0 with a correct row.
